fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: scoreboarded dispatch to a fixed-latency FP core, store
// dispatch, rounding-mode resolution and the fcsr frm/fflags state.
module fpu_issue_ctrl #(
    parameter int FLEN     = 32,
    parameter int LATENCY  = 4,
    parameter int NREG     = 32,
    localparam int RW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [6:0]    req_funct7,
    input  logic [2:0]    req_rm,
    input  logic [RW-1:0] req_rs1,
    input  logic [RW-1:0] req_rs2,
    input  logic [RW-1:0] req_rd,
    input  logic          req_lw,
    input  logic          req_sw,
    output logic          core_start,
    output logic [6:0]    core_funct7,
    output logic [2:0]    core_rm,
    input  logic [4:0]    core_flags,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic          store_valid,
    output logic [RW-1:0] store_rs2,
    output logic          illegal,
    input  logic          csr_frm_wen,
    input  logic [2:0]    csr_frm_wdata,
    input  logic          csr_fflags_clr,
    output logic [2:0]    fcsr_frm,
    output logic [4:0]    fcsr_fflags
);

    if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
        $error("fpu_issue_ctrl: FLEN must be 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("fpu_issue_ctrl: LATENCY must be in 1..8");
    end

    logic [NREG-1:0]    sb_q, sb_d;
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [LATENCY-1:0] pld_q, pld_d;
    logic [RW-1:0]      prd_q [LATENCY];
    logic [RW-1:0]      prd_d [LATENCY];
    logic [6:0]         funct7_q, funct7_d;
    logic [2:0]         frm_q, frm_d;
    logic [4:0]         fflags_q, fflags_d;

    logic       is_load;
    logic       hazard;
    logic       accept;
    logic       rm_bad;
    logic       issue;
    logic [2:0] rm_res;
    logic [4:0] wb_flags;

    // lw together with sw behaves as a store, so only a pure lw is a load.
    always_comb begin
        is_load = req_lw && !req_sw;
        if (is_load) begin
            hazard = sb_q[req_rd];
        end else begin
            hazard = sb_q[req_rs1] || sb_q[req_rs2] || (sb_q[req_rd] && !req_sw);
        end
        rm_res = (req_rm == 3'b111) ? frm_q : req_rm;
        rm_bad = (rm_res == 3'b101) || (rm_res == 3'b110);
        accept = n_rst && req_valid && !hazard;
        issue  = accept && !rm_bad && !req_sw;
    end

    assign req_ready   = !hazard;
    assign core_start  = issue;
    assign core_rm     = rm_res;
    assign core_funct7 = funct7_q;
    assign illegal     = accept && rm_bad;
    assign store_valid = accept && !rm_bad && req_sw;
    assign store_rs2   = req_rs2;
    assign wb_valid    = pv_q[LATENCY-1];
    assign wb_rd       = prd_q[LATENCY-1];
    assign wb_flags    = (wb_valid && !pld_q[LATENCY-1]) ? core_flags : 5'b0;
    assign fcsr_frm    = frm_q;
    assign fcsr_fflags = fflags_q;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (issue) begin
            sb_d[req_rd] = 1'b1;
        end

        pv_d  = '0;
        pld_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            prd_d[i] = prd_q[i];
        end
        pv_d[0]  = issue;
        pld_d[0] = is_load;
        prd_d[0] = req_rd;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            pld_d[i] = pld_q[i-1];
            prd_d[i] = prd_q[i-1];
        end

        funct7_d = issue ? req_funct7 : funct7_q;
        frm_d    = csr_frm_wen ? csr_frm_wdata : frm_q;
        // A clear coincident with a writeback keeps only that writeback's flags.
        fflags_d = csr_fflags_clr ? wb_flags : (fflags_q | wb_flags);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sb_q     <= '0;
            pv_q     <= '0;
            pld_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                prd_q[i] <= '0;
            end
            funct7_q <= '0;
            frm_q    <= '0;
            fflags_q <= '0;
        end else begin
            sb_q     <= sb_d;
            pv_q     <= pv_d;
            pld_q    <= pld_d;
            for (int i = 0; i < LATENCY; i++) begin
                prd_q[i] <= prd_d[i];
            end
            funct7_q <= funct7_d;
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: expected writebacks are queued at issue
// time and matched by a per-cycle monitor against wb_valid/wb_rd.
module tb_fpu_issue_ctrl;

    localparam int LAT = 4;

    logic       clk;
    logic       n_rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_funct7;
    logic [2:0] req_rm;
    logic [4:0] req_rs1, req_rs2, req_rd;
    logic       req_lw, req_sw;
    logic       core_start;
    logic [6:0] core_funct7;
    logic [2:0] core_rm;
    logic [4:0] core_flags;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       store_valid;
    logic [4:0] store_rs2;
    logic       illegal;
    logic       csr_frm_wen;
    logic [2:0] csr_frm_wdata;
    logic       csr_fflags_clr;
    logic [2:0] fcsr_frm;
    logic [4:0] fcsr_fflags;

    fpu_issue_ctrl #(.FLEN(32), .LATENCY(LAT), .NREG(32)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_funct7     (req_funct7),
        .req_rm         (req_rm),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_rd         (req_rd),
        .req_lw         (req_lw),
        .req_sw         (req_sw),
        .core_start     (core_start),
        .core_funct7    (core_funct7),
        .core_rm        (core_rm),
        .core_flags     (core_flags),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .store_valid    (store_valid),
        .store_rs2      (store_rs2),
        .illegal        (illegal),
        .csr_frm_wen    (csr_frm_wen),
        .csr_frm_wdata  (csr_frm_wdata),
        .csr_fflags_clr (csr_fflags_clr),
        .fcsr_frm       (fcsr_frm),
        .fcsr_fflags    (fcsr_fflags)
    );

    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] rm, input logic lw,
                      input logic sw);
        req_valid  = 1'b1;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_rm     = rm;
        req_lw     = lw;
        req_sw     = sw;
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_funct7 = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rm     = '0;
        req_lw     = 1'b0;
        req_sw     = 1'b0;
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rd);
        exp_t e;
        e.rd  = rd;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // Every cycle either the oldest queued writeback is due, or wb_valid must be low.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("wb_valid", {31'b0, wb_valid}, 32'd1);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        end else begin
            chk("wb_idle", {31'b0, wb_valid}, 32'd0);
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        n_rst = 1'b0;
        core_flags = '0;
        csr_frm_wen = 1'b0;
        csr_frm_wdata = '0;
        csr_fflags_clr = 1'b0;

        // reset: a pending request must not leak through
        op(7'h11, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        step();
        step();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_start", {31'b0, core_start}, 32'd0);
        chk("rst_store", {31'b0, store_valid}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_fflags", {27'b0, fcsr_fflags}, 32'd0);
        chk("rst_frm", {29'b0, fcsr_frm}, 32'd0);
        chk("rst_funct7", {25'b0, core_funct7}, 32'd0);
        idle();
        n_rst = 1'b1;
        step();

        // single op
        op(7'h11, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t1_ready", {31'b0, req_ready}, 32'd1);
        chk("t1_start", {31'b0, core_start}, 32'd1);
        chk("t1_rm", {29'b0, core_rm}, 32'd0);
        chk("t1_illegal", {31'b0, illegal}, 32'd0);
        expect_wb(5'd3);
        step();
        idle();
        chk("t1_funct7", {25'b0, core_funct7}, 32'h11);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ready_hold", {31'b0, req_ready}, 32'd1);
            step();
        end

        // RAW stall
        op(7'h01, 5'd5, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t2_start", {31'b0, core_start}, 32'd1);
        expect_wb(5'd5);
        step();
        op(7'h02, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall", {31'b0, req_ready}, 32'd0);
            chk("t2_nostart", {31'b0, core_start}, 32'd0);
            step();
        end
        chk("t2_go", {31'b0, req_ready}, 32'd1);
        chk("t2_start2", {31'b0, core_start}, 32'd1);
        expect_wb(5'd6);
        step();
        idle();
        repeat (5) step();

        // dynamic rounding mode
        csr_frm_wen = 1'b1;
        csr_frm_wdata = 3'b010;
        op(7'h03, 5'd8, 5'd1, 5'd2, 3'b111, 1'b0, 1'b0);
        chk("t3_rm_old", {29'b0, core_rm}, 32'd0);
        expect_wb(5'd8);
        step();
        csr_frm_wen = 1'b0;
        op(7'h03, 5'd9, 5'd1, 5'd2, 3'b111, 1'b0, 1'b0);
        chk("t3_frm", {29'b0, fcsr_frm}, 32'd2);
        chk("t3_rm_dyn", {29'b0, core_rm}, 32'd2);
        expect_wb(5'd9);
        step();
        op(7'h03, 5'd12, 5'd1, 5'd2, 3'b100, 1'b0, 1'b0);
        chk("t3_rm_static", {29'b0, core_rm}, 32'd4);
        expect_wb(5'd12);
        step();
        csr_frm_wen = 1'b1;
        csr_frm_wdata = 3'b101;
        idle();
        step();
        csr_frm_wen = 1'b0;
        op(7'h03, 5'd10, 5'd1, 5'd2, 3'b111, 1'b0, 1'b0);
        chk("t3_illegal", {31'b0, illegal}, 32'd1);
        chk("t3_ill_nostart", {31'b0, core_start}, 32'd0);
        chk("t3_ill_ready", {31'b0, req_ready}, 32'd1);
        step();
        op(7'h03, 5'd11, 5'd10, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t3_ill_pulse", {31'b0, illegal}, 32'd0);
        chk("t3_ill_nosb", {31'b0, req_ready}, 32'd1);
        chk("t3_start", {31'b0, core_start}, 32'd1);
        expect_wb(5'd11);
        step();
        op(7'h03, 5'd14, 5'd1, 5'd2, 3'b110, 1'b0, 1'b0);
        chk("t3_ill_static", {31'b0, illegal}, 32'd1);
        step();
        csr_frm_wen = 1'b1;
        csr_frm_wdata = 3'b000;
        idle();
        step();
        csr_frm_wen = 1'b0;
        repeat (5) step();

        // flag accumulation and clear
        chk("t4_ff0", {27'b0, fcsr_fflags}, 32'd0);
        op(7'h04, 5'd13, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        expect_wb(5'd13);
        step();
        op(7'h04, 5'd14, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        expect_wb(5'd14);
        step();
        idle();
        core_flags = 5'b11111;
        step();
        core_flags = 5'b00000;
        step();
        core_flags = 5'b00001;
        step();
        core_flags = 5'b10000;
        step();
        core_flags = 5'b00000;
        chk("t4_accum", {27'b0, fcsr_fflags}, 32'h11);
        op(7'h04, 5'd15, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        expect_wb(5'd15);
        step();
        idle();
        repeat (3) step();
        core_flags = 5'b00100;
        csr_fflags_clr = 1'b1;
        step();
        core_flags = 5'b00000;
        csr_fflags_clr = 1'b0;
        chk("t4_clr_wb", {27'b0, fcsr_fflags}, 32'h04);
        csr_fflags_clr = 1'b1;
        step();
        csr_fflags_clr = 1'b0;
        chk("t4_clr", {27'b0, fcsr_fflags}, 32'd0);
        op(7'h05, 5'd16, 5'd1, 5'd2, 3'b000, 1'b1, 1'b0);
        chk("t4_ld_start", {31'b0, core_start}, 32'd1);
        expect_wb(5'd16);
        step();
        idle();
        repeat (3) step();
        core_flags = 5'b11111;
        step();
        core_flags = 5'b00000;
        chk("t4_ld_flags", {27'b0, fcsr_fflags}, 32'd0);

        // store hazard, store/load hazard rules
        op(7'h06, 5'd7, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        expect_wb(5'd7);
        step();
        op(7'h00, 5'd20, 5'd0, 5'd7, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_stall", {31'b0, req_ready}, 32'd0);
            chk("t5_nostore", {31'b0, store_valid}, 32'd0);
            step();
        end
        chk("t5_go", {31'b0, req_ready}, 32'd1);
        chk("t5_store", {31'b0, store_valid}, 32'd1);
        chk("t5_rs2", {27'b0, store_rs2}, 32'd7);
        chk("t5_nocore", {31'b0, core_start}, 32'd0);
        step();
        op(7'h06, 5'd21, 5'd20, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t5_nosb", {31'b0, req_ready}, 32'd1);
        expect_wb(5'd21);
        step();
        op(7'h00, 5'd21, 5'd0, 5'd3, 3'b000, 1'b1, 1'b1);
        chk("t5_rd_ignored", {31'b0, req_ready}, 32'd1);
        chk("t5_lwsw_store", {31'b0, store_valid}, 32'd1);
        chk("t5_lwsw_nocore", {31'b0, core_start}, 32'd0);
        step();
        op(7'h07, 5'd23, 5'd21, 5'd21, 3'b000, 1'b1, 1'b0);
        chk("t5_ld_ready", {31'b0, req_ready}, 32'd1);
        chk("t5_ld_start", {31'b0, core_start}, 32'd1);
        expect_wb(5'd23);
        step();
        op(7'h07, 5'd23, 5'd1, 5'd2, 3'b000, 1'b1, 1'b0);
        chk("t5_ld_rdbusy", {31'b0, req_ready}, 32'd0);
        step();
        idle();
        repeat (5) step();

        // reset mid-flight
        op(7'h08, 5'd24, 5'd1, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t6_start", {31'b0, core_start}, 32'd1);
        step();
        idle();
        step();
        n_rst = 1'b0;
        step();
        step();
        chk("t6_rst_ready", {31'b0, req_ready}, 32'd1);
        n_rst = 1'b1;
        repeat (8) step();
        op(7'h08, 5'd25, 5'd24, 5'd2, 3'b000, 1'b0, 1'b0);
        chk("t6_ready", {31'b0, req_ready}, 32'd1);
        expect_wb(5'd25);
        step();
        idle();
        repeat (6) step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
